ip_codma_sync_fifo: RTL and testbench

Generic parametrised single-clock FIFO for the codma datapath. It replaces the fixed-size per-purpose buffers (address-phase, tracker, data storage) with one instantiable block. It adds configurable width and depth, including non-power-of-two depths, plus first-word-fall-through output, occupancy count, programmable almost-full/almost-empty thresholds, synchronous flush and sticky overflow/underflow error flags. The DMA controller instantiates it once per buffer role.

---
 rtl/ip_codma_sync_fifo.sv | 156 +++++++++++++++
 tb/tb_ip_codma_sync_fifo.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ip_codma_sync_fifo.sv
//----------------------------------------------------------------------------
// ip_codma_sync_fifo
//
// Generic single-clock FIFO used for every codma buffer role (address phase,
// tracker, data storage). First-word-fall-through: the head entry is always
// visible on data_o, and pop_i acknowledges it. Depth need not be a power of
// two, so the pointers wrap explicitly at DEPTH-1.
//
// Ports:
//   clk_i          clock, all state on rising edge
//   reset_i        asynchronous active-high reset (clears storage too)
//   flush_i        synchronous clear of contents, pointers and error flags
//   push_i/data_i  write request / write data
//   pop_i          read request, acknowledges current data_o
//   data_o         head entry, all-zero while empty
//   empty_o/full_o occupancy extremes
//   count_o        current occupancy
//   almost_full_o  count >= AFULL_THR
//   almost_empty_o count <= AEMPTY_THR
//   overflow_o     sticky: push while full without a pop
//   underflow_o    sticky: pop while empty
//----------------------------------------------------------------------------
`timescale 1ns/1ps

module ip_codma_sync_fifo #(
   parameter int DATA_W     = 64,
   parameter int DEPTH      = 32,
   parameter int AFULL_THR  = DEPTH - 2,
   parameter int AEMPTY_THR = 1,
   parameter int CNT_W      = $clog2(DEPTH + 1)
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              flush_i,
   input  logic              push_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              pop_i,
   output logic [DATA_W-1:0] data_o,
   output logic              empty_o,
   output logic              full_o,
   output logic [CNT_W-1:0]  count_o,
   output logic              almost_full_o,
   output logic              almost_empty_o,
   output logic              overflow_o,
   output logic              underflow_o
);

   localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;

   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AFULL_THR);
   localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AEMPTY_THR);

   logic [DATA_W-1:0] storage_reg [DEPTH];
   logic [DEPTH-1:0]  wr_en;

   logic [PTR_W-1:0] wptr_reg, wptr_next;
   logic [PTR_W-1:0] rptr_reg, rptr_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic             overflow_reg, overflow_next;
   logic             underflow_reg, underflow_next;

   logic push_acc;
   logic pop_acc;

   // Explicit wrap so non-power-of-two depths work.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   // Status is purely combinational from the registered count.
   assign empty_o        = (count_reg == '0);
   assign full_o         = (count_reg == CNT_FULL);
   assign count_o        = count_reg;
   assign almost_full_o  = (count_reg >= CNT_AF);
   assign almost_empty_o = (count_reg <= CNT_AE);
   assign overflow_o     = overflow_reg;
   assign underflow_o    = underflow_reg;

   // A pop frees the slot a push on a full FIFO needs, so both are accepted.
   assign push_acc = push_i & (~full_o | pop_i);
   assign pop_acc  = pop_i & ~empty_o;

   assign data_o = empty_o ? '0 : storage_reg[rptr_reg];

   // Per-entry write enables; flush discards a same-cycle push.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = push_acc & ~flush_i & (wptr_reg == PTR_W'(gi));
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            storage_reg[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (wr_en[i]) begin
               storage_reg[i] <= data_i;
            end
         end
      end
   end

   always_comb begin
      wptr_next      = wptr_reg;
      rptr_next      = rptr_reg;
      count_next     = count_reg;
      overflow_next  = overflow_reg;
      underflow_next = underflow_reg;
      if (flush_i) begin
         wptr_next      = '0;
         rptr_next      = '0;
         count_next     = '0;
         overflow_next  = 1'b0;
         underflow_next = 1'b0;
      end else begin
         if (push_acc) begin
            wptr_next = ptr_inc(wptr_reg);
         end
         if (pop_acc) begin
            rptr_next = ptr_inc(rptr_reg);
         end
         case ({push_acc, pop_acc})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
         endcase
         if (push_i && full_o && !pop_i) begin
            overflow_next = 1'b1;
         end
         // Raised even when a same-cycle push is accepted into the empty FIFO.
         if (pop_i && empty_o) begin
            underflow_next = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wptr_reg      <= '0;
         rptr_reg      <= '0;
         count_reg     <= '0;
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else begin
         wptr_reg      <= wptr_next;
         rptr_reg      <= rptr_next;
         count_reg     <= count_next;
         overflow_reg  <= overflow_next;
         underflow_reg <= underflow_next;
      end
   end

endmodule

// File: tb/tb_ip_codma_sync_fifo.sv
`timescale 1ns/1ps

module tb_ip_codma_sync_fifo;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 6;
   localparam int AF_THR = DEPTH - 2;
   localparam int AE_THR = 1;
   localparam int CNT_W  = $clog2(DEPTH + 1);

   logic              clk_i = 1'b0;
   logic              reset_i;
   logic              flush_i;
   logic              push_i;
   logic [DATA_W-1:0] data_i;
   logic              pop_i;
   logic [DATA_W-1:0] data_o;
   logic              empty_o;
   logic              full_o;
   logic [CNT_W-1:0]  count_o;
   logic              almost_full_o;
   logic              almost_empty_o;
   logic              overflow_o;
   logic              underflow_o;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   // Reference model: a queue holding the FIFO contents plus sticky flags.
   logic [DATA_W-1:0] model_q[$];
   bit                model_ovf;
   bit                model_unf;

   ip_codma_sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clk_i          (clk_i),
      .reset_i        (reset_i),
      .flush_i        (flush_i),
      .push_i         (push_i),
      .data_i         (data_i),
      .pop_i          (pop_i),
      .data_o         (data_o),
      .empty_o        (empty_o),
      .full_o         (full_o),
      .count_o        (count_o),
      .almost_full_o  (almost_full_o),
      .almost_empty_o (almost_empty_o),
      .overflow_o     (overflow_o),
      .underflow_o    (underflow_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL cyc %0d %s: got 0x%0h expected 0x%0h", cyc, tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      model_q.delete();
      model_ovf = 1'b0;
      model_unf = 1'b0;
   endtask

   // Applies one clock of the FIFO's rules to the model.
   task automatic model_step(input bit fl, input bit pu, input bit po, input logic [DATA_W-1:0] d);
      int  n;
      bit  is_full;
      bit  is_empty;
      if (fl) begin
         model_reset();
      end else begin
         n        = model_q.size();
         is_full  = (n == DEPTH);
         is_empty = (n == 0);
         if (pu && is_full && !po) model_ovf = 1'b1;
         if (po && is_empty)       model_unf = 1'b1;
         if (po && !is_empty)      void'(model_q.pop_front());
         if (pu && (!is_full || po)) model_q.push_back(d);
      end
   endtask

   task automatic check_all();
      int n;
      n = model_q.size();
      check("data_o",   32'(data_o),   (n > 0) ? 32'(model_q[0]) : 32'd0);
      check("count_o",  32'(count_o),  32'(n));
      check("empty_o",  32'(empty_o),  32'(n == 0));
      check("full_o",   32'(full_o),   32'(n == DEPTH));
      check("afull_o",  32'(almost_full_o),  32'(n >= AF_THR));
      check("aempty_o", 32'(almost_empty_o), 32'(n <= AE_THR));
      check("ovf_o",    32'(overflow_o),     32'(model_ovf));
      check("unf_o",    32'(underflow_o),    32'(model_unf));
   endtask

   // Called 1 ns after a rising edge: drive, clock, update model, compare.
   task automatic cycle(input bit fl, input bit pu, input bit po, input logic [DATA_W-1:0] d);
      flush_i = fl;
      push_i  = pu;
      pop_i   = po;
      data_i  = d;
      @(posedge clk_i);
      model_step(fl, pu, po, d);
      #1;
      cyc++;
      check_all();
      $display("cyc %0d flush=%0b push=%0b pop=%0b din=%02h -> dout=%02h cnt=%0d ovf=%0b unf=%0b",
               cyc, fl, pu, po, d, data_o, count_o, overflow_o, underflow_o);
   endtask

   task automatic idle_inputs();
      flush_i = 1'b0;
      push_i  = 1'b0;
      pop_i   = 1'b0;
      data_i  = '0;
   endtask

   initial begin
      reset_i = 1'b1;
      idle_inputs();
      model_reset();
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      check_all();
      reset_i = 1'b0;
      @(posedge clk_i);
      #1;

      // Fill with 0x11..0x16.
      for (int i = 0; i < DEPTH; i++) cycle(0, 1, 0, 8'(8'h11 + i));
      // Push on full without pop: dropped, overflow set.
      cycle(0, 1, 0, 8'h77);
      // Drain in order.
      for (int i = 0; i < DEPTH; i++) cycle(0, 0, 1, 8'h00);

      // Refill, then push+pop on full for 10 cycles.
      for (int i = 0; i < DEPTH; i++) cycle(0, 1, 0, 8'(8'h11 + i));
      for (int i = 0; i < 10; i++) cycle(0, 1, 1, 8'hAA);
      for (int i = 0; i < DEPTH; i++) cycle(0, 0, 1, 8'h00);

      // Empty with push+pop: push taken, underflow flagged.
      cycle(0, 1, 1, 8'h5A);
      cycle(0, 0, 1, 8'h00);
      cycle(0, 0, 1, 8'h00);

      // Overflow, then reduce to 3 entries and flush together with a push.
      for (int i = 0; i < DEPTH + 1; i++) cycle(0, 1, 0, 8'(8'h30 + i));
      for (int i = 0; i < 3; i++) cycle(0, 0, 1, 8'h00);
      cycle(1, 1, 0, 8'hEE);
      cycle(0, 0, 0, 8'h00);

      // Async reset mid-burst at count 4, between clock edges.
      for (int i = 0; i < 4; i++) cycle(0, 1, 0, 8'(8'h40 + i));
      idle_inputs();
      #2;
      reset_i = 1'b1;
      #1;
      model_reset();
      check_all();
      @(negedge clk_i);
      reset_i = 1'b0;
      @(posedge clk_i);
      #1;
      cycle(0, 1, 0, 8'hC3);
      cycle(0, 0, 1, 8'h00);

      // Randomised traffic with shifting push/pop bias.
      for (int i = 0; i < 1500; i++) begin
         int  phase;
         bit  fl;
         bit  pu;
         bit  po;
         phase = (i / 100) % 3;
         fl = ($urandom_range(0, 59) == 0);
         case (phase)
            0:       begin pu = ($urandom_range(0, 9) < 7); po = ($urandom_range(0, 9) < 3); end
            1:       begin pu = ($urandom_range(0, 9) < 3); po = ($urandom_range(0, 9) < 7); end
            default: begin pu = ($urandom_range(0, 1) == 1); po = ($urandom_range(0, 1) == 1); end
         endcase
         cycle(fl, pu, po, 8'($urandom));
      end

      idle_inputs();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
